// File: rtl/prog_updown_counter.sv
// Up/down counter with programmable limit, variable step and wrap/saturate/one-shot end modes.
// Sticky overflow/underflow flags; done latches in one-shot mode until the next load.
module prog_updown_counter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_n,
  input  logic [WIDTH-1:0]  data_load,
  input  logic              ce,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  limit,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count_out,
  output logic              zero,
  output logic              max_count,
  output logic              wrap_pulse,
  output logic              ovf_sticky,
  output logic              unf_sticky,
  output logic              done
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  localparam logic [WIDTH:0] ONE = 1;

  mode_e          mode_sel;
  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] wrap_up_x;
  logic [WIDTH:0] wrap_dn_x;
  logic           over;
  logic           under;
  logic           counting;

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             ovf_set;
  logic             unf_set;
  logic             done_set;
  logic [WIDTH-1:0] load_val;

  assign mode_sel  = mode_e'(mode);
  assign cnt_x     = {1'b0, count_out};
  assign lim_x     = {1'b0, limit};
  assign step_x    = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign sum_x     = cnt_x + step_x;
  assign wrap_up_x = sum_x - lim_x - ONE;
  assign wrap_dn_x = cnt_x + lim_x + ONE - step_x;
  assign over      = sum_x > lim_x;
  assign under     = step_x > cnt_x;
  assign counting  = ce && (step != '0) && !done;
  assign load_val  = (data_load > limit) ? limit : data_load;

  assign zero      = (count_out == '0);
  assign max_count = (count_out == limit);

  // Load is handled in the register block; this only covers count/hold on a non-load edge.
  always_comb begin
    count_d  = count_out;
    wrap_d   = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    done_set = 1'b0;
    if (counting) begin
      if (count_out > limit) begin
        count_d = limit;
      end else if (up_down) begin
        if (over) begin
          ovf_set = 1'b1;
          unique case (mode_sel)
            MODE_SAT: count_d = limit;
            MODE_ONESHOT: begin
              count_d  = limit;
              done_set = 1'b1;
            end
            default: begin
              count_d = wrap_up_x[WIDTH-1:0];
              wrap_d  = 1'b1;
            end
          endcase
        end else begin
          count_d = sum_x[WIDTH-1:0];
        end
      end else begin
        if (under) begin
          unf_set = 1'b1;
          unique case (mode_sel)
            MODE_SAT: count_d = '0;
            MODE_ONESHOT: begin
              count_d  = '0;
              done_set = 1'b1;
            end
            default: begin
              count_d = wrap_dn_x[WIDTH-1:0];
              wrap_d  = 1'b1;
            end
          endcase
        end else begin
          count_d = count_out - step_x[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_out  <= '0;
      wrap_pulse <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
      done       <= 1'b0;
    end else if (!load_n) begin
      count_out  <= load_val;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;
    end else begin
      count_out  <= count_d;
      wrap_pulse <= wrap_d;
      done       <= done | done_set;
      // A new event in the same cycle as clr_flags keeps its flag set.
      ovf_sticky <= ovf_set | (ovf_sticky & ~clr_flags);
      unf_sticky <= unf_set | (unf_sticky & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_prog_updown_counter.sv
// Scoreboard bench for prog_updown_counter: the driver queues hand-computed expectations per edge,
// a monitor pops and compares them shortly after each rising edge.
module tb_prog_updown_counter;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_n;
  logic [WIDTH-1:0]  data_load;
  logic              ce;
  logic              up_down;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  limit;
  logic              clr_flags;
  logic [WIDTH-1:0]  count_out;
  logic              zero;
  logic              max_count;
  logic              wrap_pulse;
  logic              ovf_sticky;
  logic              unf_sticky;
  logic              done;

  typedef struct {
    string      name;
    logic [7:0] cnt;
    logic       zr;
    logic       mx;
    logic       wp;
    logic       ovf;
    logic       unf;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  prog_updown_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_n(load_n), .data_load(data_load), .ce(ce),
    .up_down(up_down), .step(step), .mode(mode), .limit(limit), .clr_flags(clr_flags),
    .count_out(count_out), .zero(zero), .max_count(max_count), .wrap_pulse(wrap_pulse),
    .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    end
  endtask

  // Monitor: every rising edge produces an output state, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk1(e.name, "count",  count_out,        e.cnt);
        chk1(e.name, "zero",   {7'd0, zero},       {7'd0, e.zr});
        chk1(e.name, "max",    {7'd0, max_count},  {7'd0, e.mx});
        chk1(e.name, "wrap",   {7'd0, wrap_pulse}, {7'd0, e.wp});
        chk1(e.name, "ovf",    {7'd0, ovf_sticky}, {7'd0, e.ovf});
        chk1(e.name, "unf",    {7'd0, unf_sticky}, {7'd0, e.unf});
        chk1(e.name, "done",   {7'd0, done},       {7'd0, e.dn});
      end
    end
  end

  // One edge: drive inputs at the falling edge and queue the expected post-edge state.
  task automatic cyc(input string nm, input logic r, input logic ld, input logic [7:0] d,
                     input logic c, input logic ud, input logic [3:0] st, input logic [1:0] md,
                     input logic [7:0] lim, input logic clr,
                     input logic [7:0] ecnt, input logic ewp, input logic eovf,
                     input logic eunf, input logic edn);
    exp_t e;
    @(negedge clk);
    rst_n = r; load_n = ld; data_load = d; ce = c; up_down = ud;
    step = st; mode = md; limit = lim; clr_flags = clr;
    e.name = nm; e.cnt = ecnt; e.zr = (ecnt == 8'd0); e.mx = (ecnt == lim);
    e.wp = ewp; e.ovf = eovf; e.unf = eunf; e.dn = edn;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; load_n = 1'b1; data_load = '0; ce = 1'b0; up_down = 1'b1;
    step = 4'd1; mode = 2'd0; limit = 8'd7; clr_flags = 1'b0;
    //   name        r  ld d    ce ud st md lim  clr  cnt  wp ovf unf dn
    cyc("reset",     0, 1, 0,   0, 1, 1, 0, 7,   0,   0,   0, 0,  0,  0);
    cyc("ld5",       1, 0, 5,   0, 1, 1, 0, 7,   0,   5,   0, 0,  0,  0);
    cyc("up6",       1, 1, 0,   1, 1, 1, 0, 7,   0,   6,   0, 0,  0,  0);
    cyc("up7",       1, 1, 0,   1, 1, 1, 0, 7,   0,   7,   0, 0,  0,  0);
    cyc("wrap0",     1, 1, 0,   1, 1, 1, 0, 7,   0,   0,   1, 1,  0,  0);
    cyc("hold",      1, 1, 0,   0, 1, 1, 0, 7,   0,   0,   0, 1,  0,  0);
    cyc("clr1",      1, 1, 0,   0, 1, 1, 0, 7,   1,   0,   0, 0,  0,  0);
    cyc("ld198",     1, 0, 198, 0, 1, 3, 1, 200, 0,   198, 0, 0,  0,  0);
    cyc("sat200",    1, 1, 0,   1, 1, 3, 1, 200, 0,   200, 0, 1,  0,  0);
    cyc("sat200b",   1, 1, 0,   1, 1, 3, 1, 200, 0,   200, 0, 1,  0,  0);
    cyc("clr2",      1, 1, 0,   0, 1, 3, 1, 200, 1,   200, 0, 0,  0,  0);
    cyc("ld4",       1, 0, 4,   0, 0, 3, 2, 200, 0,   4,   0, 0,  0,  0);
    cyc("os_dn1",    1, 1, 0,   1, 0, 3, 2, 200, 0,   1,   0, 0,  0,  0);
    cyc("os_done",   1, 1, 0,   1, 0, 3, 2, 200, 0,   0,   0, 0,  1,  1);
    cyc("os_hold",   1, 1, 0,   1, 0, 3, 2, 200, 0,   0,   0, 0,  1,  1);
    cyc("os_mdchg",  1, 1, 0,   1, 1, 3, 0, 200, 0,   0,   0, 0,  1,  1);
    cyc("ld9",       1, 0, 9,   0, 0, 3, 2, 200, 0,   9,   0, 0,  1,  0);
    cyc("ld1",       1, 0, 1,   0, 0, 4, 0, 9,   0,   1,   0, 0,  1,  0);
    cyc("clr3",      1, 1, 0,   0, 0, 4, 0, 9,   1,   1,   0, 0,  0,  0);
    cyc("wrapdn7",   1, 1, 0,   1, 0, 4, 0, 9,   0,   7,   1, 0,  1,  0);
    cyc("clr4",      1, 1, 0,   0, 0, 4, 0, 9,   1,   7,   0, 0,  0,  0);
    cyc("ld250",     1, 0, 250, 0, 1, 1, 0, 100, 0,   100, 0, 0,  0,  0);
    cyc("oor50",     1, 1, 0,   1, 1, 1, 0, 50,  0,   50,  0, 0,  0,  0);
    cyc("wrap50",    1, 1, 0,   1, 1, 1, 0, 50,  0,   0,   1, 1,  0,  0);
    cyc("clr5",      1, 1, 0,   0, 1, 1, 0, 50,  1,   0,   0, 0,  0,  0);
    cyc("ld7",       1, 0, 7,   0, 1, 1, 0, 7,   0,   7,   0, 0,  0,  0);
    cyc("rst_ovr",   0, 0, 5,   1, 1, 1, 0, 7,   0,   0,   0, 0,  0,  0);
    cyc("wrapdn_l0", 1, 1, 0,   1, 0, 1, 0, 7,   0,   7,   1, 0,  1,  0);
    cyc("set_clr",   1, 1, 0,   1, 1, 2, 0, 7,   1,   1,   1, 1,  0,  0);
    cyc("sat_dn",    1, 1, 0,   1, 0, 3, 1, 7,   0,   0,   0, 1,  1,  0);
    cyc("m3_up5",    1, 1, 0,   1, 1, 5, 3, 7,   0,   5,   0, 1,  1,  0);
    cyc("m3_wrap",   1, 1, 0,   1, 1, 4, 3, 7,   0,   1,   1, 1,  1,  0);
    cyc("step0",     1, 1, 0,   1, 1, 0, 0, 7,   0,   1,   0, 1,  1,  0);
    cyc("dn_plain",  1, 1, 0,   1, 0, 1, 0, 7,   0,   0,   0, 1,  1,  0);
    @(negedge clk);
    ce = 1'b0; load_n = 1'b1; clr_flags = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=%0t required=<100000 sim time", $time);
    $fatal(1, "timeout");
  end

endmodule
